// File: rtl/tone_pkg.sv
// Shared state encoding and default sizing for the tone generator / tone detector pair.
package tone_pkg;

  typedef enum logic [1:0] {
    S_SILENT = 2'd0,
    S_ARMED  = 2'd1,
    S_TRACK  = 2'd2
  } tone_state_e;

  localparam int TONE_CNT_W       = 16;
  localparam int TONE_TIMEOUT_CYC = 50000;
  localparam int TONE_MIN_PERIOD  = 8;

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchroniser for the asynchronous tone input plus a rising-edge pulse.
// Free-running: the enable of the consumer does not gate it.
module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tone_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/tone_period_detector.sv
// Measures rising-edge to rising-edge period of a square-wave tone, rejects glitches,
// flags silence after a timeout and declares lock after LOCK_N consecutive matching periods.
module tone_period_detector
  import tone_pkg::*;
#(
  parameter int CNT_W       = TONE_CNT_W,
  parameter int TIMEOUT_CYC = TONE_TIMEOUT_CYC,
  parameter int MIN_PERIOD  = TONE_MIN_PERIOD,
  parameter int TOL         = 4,
  parameter int LOCK_N      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid,
  output logic             locked,
  output logic             silence,
  output logic             glitch
);

  localparam int MATCH_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   MIN_V     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]   ONE_V     = CNT_W'(1);
  localparam logic [CNT_W:0]     TOL_V     = (CNT_W + 1)'(TOL);
  localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_N);

  tone_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic                 pv_q, pv_d;
  logic                 locked_q, locked_d;
  logic                 silence_q, silence_d;
  logic                 glitch_q, glitch_d;

  logic                 tone_edge;
  logic                 timeout;
  logic                 short_edge;
  logic [CNT_W:0]       diff;
  logic [MATCH_W-1:0]   match_inc;

  tone_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .tone_in(tone_in),
    .edge_o (tone_edge)
  );

  assign timeout    = (state_q != S_SILENT) && (cnt_q == TIMEOUT_V);
  assign short_edge = (cnt_q < MIN_V);

  // One extra bit keeps the magnitude exact; the timeout bounds cnt so nothing wraps.
  assign diff = (cnt_q >= period_q) ? ({1'b0, cnt_q} - {1'b0, period_q})
                                    : ({1'b0, period_q} - {1'b0, cnt_q});

  assign match_inc = (match_q >= LOCK_V) ? LOCK_V : (match_q + 1'b1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    match_d   = match_q;
    pv_d      = 1'b0;
    locked_d  = locked_q;
    silence_d = silence_q;
    glitch_d  = 1'b0;

    if (ena) begin
      case (state_q)
        S_SILENT: begin
          if (tone_edge) begin
            state_d   = S_ARMED;
            cnt_d     = ONE_V;
            silence_d = 1'b0;
          end
        end

        S_ARMED, S_TRACK: begin
          if (timeout) begin
            // An edge landing on the timeout cycle re-arms instead of going silent.
            match_d  = '0;
            locked_d = 1'b0;
            if (tone_edge) begin
              state_d = S_ARMED;
              cnt_d   = ONE_V;
            end else begin
              state_d   = S_SILENT;
              cnt_d     = '0;
              silence_d = 1'b1;
            end
          end else if (tone_edge && !short_edge) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = ONE_V;
            if (state_q == S_ARMED) begin
              state_d = S_TRACK;
              match_d = '0;
            end else if (diff <= TOL_V) begin
              match_d = match_inc;
              if (match_inc == LOCK_V) begin
                locked_d = 1'b1;
              end
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else begin
            glitch_d = tone_edge;
            cnt_d    = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d   = S_SILENT;
          cnt_d     = '0;
          match_d   = '0;
          locked_d  = 1'b0;
          silence_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_SILENT;
      cnt_q     <= '0;
      period_q  <= '0;
      match_q   <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      silence_q <= 1'b1;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      match_q   <= match_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      silence_q <= silence_d;
      glitch_q  <= glitch_d;
    end
  end

  assign period_o     = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign silence      = silence_q;
  assign glitch       = glitch_q;

endmodule
